// File: rtl/seg7_scan_ctrl_pkg.sv
// seg7_scan_ctrl_pkg: segment glyphs {g,f,e,d,c,b,a} and scan FSM state codes
package seg7_scan_ctrl_pkg;
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] GLYPH [16] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
                                        SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F};
  typedef enum logic {ST_GUARD, ST_SHOW} scan_st_t;
endpackage

// File: rtl/seg7_hex_dec.sv
// seg7_hex_dec: {blank, nibble} to active-high segment pattern
module seg7_hex_dec
  import seg7_scan_ctrl_pkg::*;
(
  input  logic [4:0] i_digit,
  output logic [6:0] o_seg
);
  assign o_seg = i_digit[4] ? SEG_BLANK : GLYPH[i_digit[3:0]];
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: 8-digit multiplexed 7-segment scanner with tear-free shadow/active buffers
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIG = 8,
  parameter int DIV     = 50000,
  parameter int GUARD   = 64,
  localparam int IDX_W  = $clog2(NUM_DIG),
  localparam int CNT_W  = $clog2(DIV)
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [2:0]         wr_addr,
  input  logic [3:0]         wr_data,
  input  logic               wr_blank,
  input  logic               commit,
  output logic               busy,
  output logic [6:0]         seg,
  output logic [NUM_DIG-1:0] seg_en,
  output logic [IDX_W-1:0]   digit_idx,
  output logic               frame_tick
);
  scan_st_t           r_state, w_next_state;
  logic [CNT_W-1:0]   r_div_cnt;
  logic [IDX_W-1:0]   r_digit_idx;
  logic               r_frame_tick, r_busy;
  logic [6:0]         r_seg, w_seg_nxt, w_dec_seg;
  logic [NUM_DIG-1:0] r_seg_en, w_seg_en_nxt;
  logic [4:0]         r_shadow [NUM_DIG];
  logic [4:0]         r_active [NUM_DIG];
  logic               w_last_cnt, w_guard_end, w_slot_end, w_frame_end, w_copy;

  assign w_last_cnt  = r_div_cnt == CNT_W'(DIV - 1);
  assign w_guard_end = r_div_cnt == CNT_W'(GUARD - 1);
  assign w_slot_end  = (r_state == ST_SHOW) && w_last_cnt;
  assign w_frame_end = w_slot_end && (r_digit_idx == IDX_W'(NUM_DIG - 1));
  assign w_copy      = r_busy && r_frame_tick;

  seg7_hex_dec u_dec (.i_digit(r_active[r_digit_idx]), .o_seg(w_dec_seg));

  // slot timer: div_cnt free-runs 0..DIV-1 across guard and show phases
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_div_cnt <= '0;
    else        r_div_cnt <= w_last_cnt ? '0 : r_div_cnt + 1'b1;

  // FSM state register and digit/frame sequencing
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state      <= ST_GUARD;
      r_digit_idx  <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_frame_tick <= w_frame_end;
      if (w_slot_end) r_digit_idx <= w_frame_end ? '0 : r_digit_idx + 1'b1;
    end

  // next state plus unregistered view of the pins for the current slot
  always_comb begin
    w_next_state = r_state;
    w_seg_nxt    = SEG_BLANK;
    w_seg_en_nxt = '0;
    if (r_state == ST_GUARD) begin
      if (w_guard_end) w_next_state = ST_SHOW;
    end else begin
      w_seg_en_nxt = {{(NUM_DIG-1){1'b0}}, 1'b1} << r_digit_idx;
      w_seg_nxt    = w_dec_seg;
      if (w_last_cnt) w_next_state = ST_GUARD;
    end
  end

  // pin registers: glitch-free outputs with one cycle of fixed latency
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_seg    <= SEG_BLANK;
      r_seg_en <= '0;
    end else begin
      r_seg    <= w_seg_nxt;
      r_seg_en <= w_seg_en_nxt;
    end

  // commit handshake: a commit while busy is dropped, copy lands on the frame boundary
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_busy <= 1'b0;
    else        r_busy <= w_copy ? 1'b0 : (r_busy | commit);

  // digit buffers: reset dark, shadow takes writes, active snapshots pre-write shadow on copy
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIG; i++) begin
        r_shadow[i] <= 5'h10;
        r_active[i] <= 5'h10;
      end
    end else begin
      if (w_copy) r_active <= r_shadow;
      if (wr_en && (32'(wr_addr) < NUM_DIG)) r_shadow[wr_addr] <= {wr_blank, wr_data};
    end

  assign busy       = r_busy;
  assign seg        = r_seg;
  assign seg_en     = r_seg_en;
  assign digit_idx  = r_digit_idx;
  assign frame_tick = r_frame_tick;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: scoreboard bench for the scan controller (NUM_DIG=8, DIV=8, GUARD=2)
module tb_seg7_scan_ctrl;
  localparam int NUM_DIG = 8, DIV = 8, GUARD = 2, FRAME = NUM_DIG * DIV;

  logic       clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, wr_blank = 1'b0, commit = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic       busy, frame_tick;
  logic [6:0] seg;
  logic [7:0] seg_en;
  logic [2:0] digit_idx;

  typedef struct {logic [6:0] seg; logic [7:0] seg_en; logic [2:0] idx; logic tick; logic busy;} exp_t;
  exp_t sb[$];

  int         n_chk = 0, n_fail = 0, m_n = 0;
  logic [4:0] m_shadow [8], m_active [8];
  logic       m_busy, m_tick;

  seg7_scan_ctrl #(.NUM_DIG(NUM_DIG), .DIV(DIV), .GUARD(GUARD)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_blank(wr_blank), .commit(commit), .busy(busy), .seg(seg), .seg_en(seg_en),
    .digit_idx(digit_idx), .frame_tick(frame_tick));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  task automatic model_reset();
    m_n = 0; m_busy = 1'b0; m_tick = 1'b0;
    for (int i = 0; i < 8; i++) begin m_shadow[i] = 5'h10; m_active[i] = 5'h10; end
  endtask

  task automatic step();
    exp_t e;
    int c, d;
    logic show, copy;
    c = m_n % DIV; d = (m_n / DIV) % NUM_DIG; show = c >= GUARD;
    copy = m_busy && m_tick;
    e.seg_en = show ? 8'(1 << d) : 8'h00;
    e.seg    = (show && !m_active[d][4]) ? glyph(m_active[d][3:0]) : 7'h00;
    m_n++;
    e.idx  = 3'((m_n / DIV) % NUM_DIG);
    e.tick = (m_n % FRAME) == 0;
    e.busy = copy ? 1'b0 : ((commit && !m_busy) ? 1'b1 : m_busy);
    if (copy) m_active = m_shadow;
    if (wr_en) m_shadow[wr_addr] = {wr_blank, wr_data};
    m_busy = e.busy; m_tick = e.tick;
    @(posedge clk);
    sb.push_back(e);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to(input int phase);
    int k = 0;
    while ((m_n % FRAME) != phase && k < 2 * FRAME) begin step(); k++; end
    if (k >= 2 * FRAME) chk("run_to_timeout", k, 0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [3:0] d, input logic b);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_blank = b;
    step();
    wr_en = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1; step(); commit = 1'b0;
  endtask

  task automatic chk_reset_pins(input string tag);
    chk({tag, "_seg_en"}, seg_en, 8'h00);
    chk({tag, "_seg"}, seg, 7'h00);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_idx"}, digit_idx, 3'd0);
    chk({tag, "_tick"}, frame_tick, 1'b0);
  endtask

  always @(negedge clk)
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("seg", seg, e.seg);
      chk("seg_en", seg_en, e.seg_en);
      chk("onehot0", $onehot0(seg_en), 1'b1);
      chk("digit_idx", digit_idx, e.idx);
      chk("frame_tick", frame_tick, e.tick);
      chk("busy", busy, e.busy);
    end

  initial begin
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_reset_pins("rst_hold");
    end
    rst_n = 1'b1;
    run(20);
    for (int i = 0; i < 8; i++) wr(3'(i), 4'(i), 1'b0);
    pulse_commit();
    run(2 * FRAME + 10);
    wr(3'd5, 4'h9, 1'b1);
    pulse_commit();
    run(FRAME + 20);
    wr(3'd1, 4'hA, 1'b0);
    run_to(0);
    pulse_commit();
    run(2 * FRAME);
    pulse_commit();
    run(3);
    pulse_commit();
    run_to(0);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'hE; wr_blank = 1'b0; commit = 1'b1;
    step();
    wr_en = 1'b0; commit = 1'b0;
    run(FRAME + 8);
    pulse_commit();
    run(2 * FRAME);
    pulse_commit();
    run_to(4 * DIV + 4);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_reset_pins("rst_mid");
    model_reset();
    @(posedge clk); #1;
    chk_reset_pins("rst_mid_hold");
    rst_n = 1'b1;
    run(FRAME + 16);
    @(negedge clk); #1;
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
